ip_frame_feeder: RTL and testbench
==================================

// Module: ip_frame_feeder
// PURPOSE
//  Frame-buffering input stage in front of the first radix-2 SDF butterfly stage.
//  Accepts raw signed integer samples over a valid/ready stream and converts each to
//  fpt Q16.16 (value<<16). Collects one full frame of LENGTH samples, then streams the
//  frame in natural order to the R2SDF pipeline, one sample per handshake.
//  Marks the first (SOF) and last (EOF) sample of each frame.
// PARAMETERS
//  LENGTH     8   samples per FFT frame; power of 2, >=2
//  FRAC_BITS  16  fractional bits of fpt; the conversion shift amount
//  AW  $clog2(LENGTH)  pointer width (localparam; not overridable)
// PORTS
//  clk        in   1   single clock; all logic on posedge
//  rst_n      in   1   asynchronous, active-low reset
//  clear      in   1   sync abort: drop current frame, return to FILL
//  in_valid   in   1   raw sample valid
//  in_ready   out  1   feeder can accept a sample
//  in_data    in   32  raw signed integer sample (t_ip_raw)
//  out_valid  out  1   fpt sample valid toward R2SDF stage 0
//  out_ready  in   1   downstream accepts sample
//  out_data   out  32  fpt sample, Q16.16
//  out_sof    out  1   high with out_valid on frame sample 0
//  out_eof    out  1   high with out_valid on frame sample LENGTH-1
//  sat_seen   out  1   sticky: a sample saturated in conversion (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst_n=0, async): state=FILL, wr_ptr=rd_ptr=0, in_ready=1, out_valid=0,
//   out_sof=0, out_eof=0, out_data=0, sat_seen=0. Buffer contents are don't-care.
//  FSM, 2 states:
//   FILL:  in_ready=1, out_valid=0. On in_valid&&in_ready: buf[wr_ptr]<=conv(in_data),
//          wr_ptr++. Accepting sample at wr_ptr==LENGTH-1: wr_ptr<=0, next state DRAIN.
//   DRAIN: in_ready=0, out_valid=1, out_data=buf[rd_ptr], out_sof=(rd_ptr==0),
//          out_eof=(rd_ptr==LENGTH-1). On out_valid&&out_ready: rd_ptr++. Transfer at
//          rd_ptr==LENGTH-1: rd_ptr<=0, next state FILL.
//  Latency: first out_valid is 1 cycle after the clock that accepted the last input.
//   Throughput is 1 sample/cycle each phase. No fill/drain overlap: 2*LENGTH cycles
//   per frame minimum.
//  Stall: while out_valid&&!out_ready, out_data/out_sof/out_eof are held stable.
//  in_data is ignored whenever in_ready=0. No input overflow is possible.
//  Pointers wrap only through the explicit LENGTH-1 terminal; they never free-run.
//  clear=1 (highest priority, beats both handshakes in the same cycle): next cycle
//   state=FILL, wr_ptr=rd_ptr=0, out_valid=0. Any partial frame is discarded.
//   sat_seen is unaffected; only rst_n clears it.
//  rst_n asserted mid-FILL or mid-DRAIN: immediate return to reset values.
//   No partial frame is emitted.
//  Arithmetic: conv(x) = {x[31-FRAC_BITS:0], FRAC_BITS'b0}. The top FRAC_BITS bits of x
//   are dropped unless saturation is compiled in.
// CONFIGURATION
//  FEEDER_SAT_EN defined: if x > 32767, conv = 32'h7FFF_FFFF.
//   If x < -32768, conv = 32'h8000_0000.
//   Any clamp on an accepted sample sets sat_seen=1 on the next clock.
//  FEEDER_SAT_EN undefined: plain truncating shift, as above. sat_seen is tied 0.
// STRUCTURE
//  fft_pkg (shared): typedef fpt (logic signed [31:0]), typedef t_ip_raw
//   (logic signed [31:0]), localparam FPT_FRAC_BITS=16, FPT_MAX/FPT_MIN constants.
//  Sub-module fpt_from_int: combinational conv() plus a sat flag. It contains the only
//   `ifdef FEEDER_SAT_EN. ip_frame_feeder holds the FSM, pointers and buffer.
// TESTING
//  1 Reset, feed 1..8 back-to-back, out_ready=1 -> 8 outputs 0x0001_0000..0x0008_0000;
//    SOF on first, EOF on last; in_ready low exactly 8 cycles.
//  2 Random out_ready toggling during DRAIN -> out_data/SOF/EOF stable while stalled;
//    order preserved; no loss or duplication.
//  3 Feed -3 -> out_data 0xFFFD_0000. Feed 40000 -> 0x7FFF_FFFF and sat_seen=1 with
//    SAT_EN; without it, 0x9C40_0000 and sat_seen=0.
//  4 Assert clear after 5 inputs, then feed 8 new samples (10..17) -> only 10..17 emitted,
//    SOF on 10.
//  5 rst_n low for 1 cycle mid-DRAIN (rd_ptr=3) -> out_valid=0 at once; in_ready=1
//    after release; the next frame streams correctly.
//  6 Two consecutive frames with in_valid held high -> second frame accepted only after
//    the first's EOF transfer; SOF/EOF correct on both.

Source files
------------

// File: rtl/ip_frame_feeder_pkg.sv
// Shared fixed-point types and constants for the FFT front end.
// Q16.16 "fpt" samples, raw integer input samples and the feeder FSM encoding.
package ip_frame_feeder_pkg;

    typedef logic signed [31:0] fpt;
    typedef logic signed [31:0] t_ip_raw;

    localparam int FPT_FRAC_BITS = 16;
    localparam fpt FPT_MAX       = 32'sh7FFF_FFFF;
    localparam fpt FPT_MIN       = 32'sh8000_0000;
    localparam fpt FPT_ZERO      = 32'sh0000_0000;

    typedef enum logic [0:0] {
        ST_FILL  = 1'b0,
        ST_DRAIN = 1'b1
    } feeder_state_t;

endpackage

// File: rtl/ip_frame_feeder_if.sv
// Stream bundle between the sample source, the frame feeder and R2SDF stage 0.
// slave: the feeder itself; master: whatever drives raw samples and out_ready.
interface ip_frame_feeder_if;
    import ip_frame_feeder_pkg::*;

    logic    in_valid;
    logic    in_ready;
    t_ip_raw in_data;
    logic    out_valid;
    logic    out_ready;
    fpt      out_data;
    logic    out_sof;
    logic    out_eof;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sof, out_eof
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sof, out_eof
    );

endinterface

// File: rtl/ip_frame_feeder_fpt_from_int.sv
// Integer to Q16.16 conversion (value << FRAC_BITS) with a saturation flag.
// Build option FEEDER_SAT_EN: clamp out-of-range inputs to FPT_MAX/FPT_MIN and
// raise sat; without it the top FRAC_BITS bits are simply dropped and sat is 0.
module fpt_from_int
    import ip_frame_feeder_pkg::*;
#(
    parameter int FRAC_BITS = FPT_FRAC_BITS
) (
    input  t_ip_raw x,
    output fpt      y,
    output logic    sat
);

    fpt shifted_s;
    assign shifted_s = {x[31-FRAC_BITS:0], {FRAC_BITS{1'b0}}};

`ifdef FEEDER_SAT_EN
    // Largest/smallest integers whose shifted value still fits in fpt.
    localparam t_ip_raw IN_MAX = t_ip_raw'(FPT_MAX >>> FRAC_BITS);
    localparam t_ip_raw IN_MIN = t_ip_raw'(FPT_MIN >>> FRAC_BITS);

    // Clamp to the fpt range and flag any clamp.
    always_comb begin
        y   = shifted_s;
        sat = 1'b0;
        if (x > IN_MAX) begin
            y   = FPT_MAX;
            sat = 1'b1;
        end else if (x < IN_MIN) begin
            y   = FPT_MIN;
            sat = 1'b1;
        end else begin
            y   = shifted_s;
            sat = 1'b0;
        end
    end
`else
    // Truncating build: the bits shifted out are intentionally discarded.
    logic unused_hi_s;
    assign unused_hi_s = ^x[31:32-FRAC_BITS];
    assign y   = shifted_s;
    assign sat = 1'b0;
`endif

endmodule

// File: rtl/ip_frame_feeder.sv
// Frame-buffering input stage ahead of R2SDF stage 0.
// Collects LENGTH converted samples (FILL), then streams them out in natural
// order with SOF/EOF marks (DRAIN). clear aborts to an empty FILL state.
// Saturation behaviour comes from fpt_from_int (build option FEEDER_SAT_EN).
module ip_frame_feeder
    import ip_frame_feeder_pkg::*;
#(
    parameter int LENGTH    = 8,
    parameter int FRAC_BITS = FPT_FRAC_BITS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    ip_frame_feeder_if.slave   bus,
    output logic               sat_seen
);

    localparam int            AW       = $clog2(LENGTH);
    localparam logic [AW-1:0] PTR_LAST = AW'(LENGTH - 1);
    localparam logic [AW-1:0] PTR_ZERO = AW'(0);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    feeder_state_t state_r, state_nxt_s;
    logic [AW-1:0] wr_ptr_r, wr_ptr_nxt_s;
    logic [AW-1:0] rd_ptr_r, rd_ptr_nxt_s;
    fpt            mem_r [LENGTH];

    logic in_ready_r, out_valid_r, out_sof_r, out_eof_r, sat_seen_r;
    fpt   out_data_r;
    logic out_valid_nxt_s, out_sof_nxt_s, out_eof_nxt_s;
    fpt   out_data_nxt_s;

    logic in_fire_s, out_fire_s, wr_en_s;
    fpt   conv_s;
    logic sat_s;

    fpt_from_int #(.FRAC_BITS(FRAC_BITS)) u_conv (
        .x   (bus.in_data),
        .y   (conv_s),
        .sat (sat_s)
    );

    assign in_fire_s  = bus.in_valid && in_ready_r;
    assign out_fire_s = out_valid_r && bus.out_ready;

    // Next state, pointers, buffer write enable and next output values.
    always_comb begin
        state_nxt_s  = state_r;
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        wr_en_s      = 1'b0;
        if (clear) begin
            state_nxt_s  = ST_FILL;
            wr_ptr_nxt_s = PTR_ZERO;
            rd_ptr_nxt_s = PTR_ZERO;
        end else begin
            case (state_r)
                ST_FILL: begin
                    if (in_fire_s) begin
                        wr_en_s = 1'b1;
                        if (wr_ptr_r == PTR_LAST) begin
                            wr_ptr_nxt_s = PTR_ZERO;
                            state_nxt_s  = ST_DRAIN;
                        end else begin
                            wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
                        end
                    end else begin
                        wr_ptr_nxt_s = wr_ptr_r;
                    end
                end
                ST_DRAIN: begin
                    if (out_fire_s) begin
                        if (rd_ptr_r == PTR_LAST) begin
                            rd_ptr_nxt_s = PTR_ZERO;
                            state_nxt_s  = ST_FILL;
                        end else begin
                            rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
                        end
                    end else begin
                        rd_ptr_nxt_s = rd_ptr_r;
                    end
                end
                default: begin
                    state_nxt_s  = ST_FILL;
                    wr_ptr_nxt_s = PTR_ZERO;
                    rd_ptr_nxt_s = PTR_ZERO;
                end
            endcase
        end

        // Outputs are precomputed from the next state so they leave flops;
        // an unchanged rd_ptr during a stall keeps them stable.
        if (state_nxt_s == ST_DRAIN) begin
            out_valid_nxt_s = 1'b1;
            out_data_nxt_s  = mem_r[rd_ptr_nxt_s];
            out_sof_nxt_s   = (rd_ptr_nxt_s == PTR_ZERO);
            out_eof_nxt_s   = (rd_ptr_nxt_s == PTR_LAST);
        end else begin
            out_valid_nxt_s = 1'b0;
            out_data_nxt_s  = FPT_ZERO;
            out_sof_nxt_s   = 1'b0;
            out_eof_nxt_s   = 1'b0;
        end
    end

    // State, pointers and registered stream outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_FILL;
            wr_ptr_r    <= PTR_ZERO;
            rd_ptr_r    <= PTR_ZERO;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_data_r  <= FPT_ZERO;
            out_sof_r   <= 1'b0;
            out_eof_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            wr_ptr_r    <= wr_ptr_nxt_s;
            rd_ptr_r    <= rd_ptr_nxt_s;
            in_ready_r  <= (state_nxt_s == ST_FILL);
            out_valid_r <= out_valid_nxt_s;
            out_data_r  <= out_data_nxt_s;
            out_sof_r   <= out_sof_nxt_s;
            out_eof_r   <= out_eof_nxt_s;
        end
    end

    // Sticky saturation flag: set by any clamped accepted sample, cleared only by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_seen_r <= 1'b0;
        end else if (in_fire_s && !clear && sat_s) begin
            sat_seen_r <= 1'b1;
        end
    end

    // Frame buffer; contents need no reset since only written slots are ever read.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= conv_s;
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_sof   = out_sof_r;
    assign bus.out_eof   = out_eof_r;
    assign sat_seen      = sat_seen_r;

endmodule

// File: tb/tb_ip_frame_feeder.sv
// Self-checking bench for ip_frame_feeder: directed frames plus random stimulus,
// compared every cycle against a queue-based frame model.
module tb_ip_frame_feeder;
    import ip_frame_feeder_pkg::*;

    localparam int LEN = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    logic sat_seen;

    ip_frame_feeder_if bus ();

    ip_frame_feeder #(.LENGTH(LEN), .FRAC_BITS(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .bus      (bus),
        .sat_seen (sat_seen)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    logic [31:0] fill_q [$];
    logic [31:0] drain_q [$];
    logic [31:0] got_q [$];
    bit          sat_exp = 1'b0;
    int          ready_low_cnt = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_conv(input int x);
        longint v;
        v = longint'(x) * 64'sd65536;
`ifdef FEEDER_SAT_EN
        if (x > 32767)  return 32'h7FFF_FFFF;
        if (x < -32768) return 32'h8000_0000;
`endif
        return v[31:0];
    endfunction

    function automatic bit ref_sat(input int x);
`ifdef FEEDER_SAT_EN
        return (x > 32767) || (x < -32768);
`else
        return (x != x);
`endif
    endfunction

    task automatic check_outputs();
        check_val("in_ready", 32'(bus.in_ready), 32'(drain_q.size() == 0));
        check_val("out_valid", 32'(bus.out_valid), 32'(drain_q.size() != 0));
        if (drain_q.size() != 0) begin
            check_val("out_data", bus.out_data, drain_q[0]);
            check_val("out_sof", 32'(bus.out_sof), 32'(drain_q.size() == LEN));
            check_val("out_eof", 32'(bus.out_eof), 32'(drain_q.size() == 1));
        end
        check_val("sat_seen", 32'(sat_seen), 32'(sat_exp));
        if (!bus.in_ready) ready_low_cnt++;
    endtask

    // One clock: check current outputs, drive new inputs, advance the model.
    task automatic cycle(input bit iv, input int idata, input bit ordy, input bit clr);
        check_outputs();
        bus.in_valid  = iv;
        bus.in_data   = idata;
        bus.out_ready = ordy;
        clear         = clr;
        if (clr) begin
            fill_q.delete();
            drain_q.delete();
        end else if (drain_q.size() != 0) begin
            if (ordy) begin
                got_q.push_back(bus.out_data);
                void'(drain_q.pop_front());
            end
        end else if (iv) begin
            fill_q.push_back(ref_conv(idata));
            if (ref_sat(idata)) sat_exp = 1'b1;
            if (fill_q.size() == LEN) begin
                drain_q = fill_q;
                fill_q.delete();
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = 32'sd0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_val("rst_out_data", bus.out_data, 32'd0);
        check_val("rst_sof_eof", {30'd0, bus.out_sof, bus.out_eof}, 32'd0);
        check_val("rst_sat", 32'(sat_seen), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: frame 1..8 back to back, downstream always ready
        got_q.delete();
        ready_low_cnt = 0;
        for (int i = 1; i <= LEN; i++) cycle(1'b1, i, 1'b1, 1'b0);
        repeat (LEN + 2) cycle(1'b0, 0, 1'b1, 1'b0);
        check_val("t1_count", 32'(got_q.size()), 32'(LEN));
        for (int k = 0; k < got_q.size(); k++)
            check_val("t1_data", got_q[k], 32'(k + 1) << 16);
        check_val("t1_ready_low", 32'(ready_low_cnt), 32'(LEN));

        // 2: random valid/ready with random in-range data
        for (int i = 0; i < 300; i++)
            cycle(1'($urandom), int'($urandom_range(0, 60000)) - 30000, 1'($urandom), 1'b0);
        cycle(1'b0, 0, 1'b1, 1'b1);

        // 3: conversion of a negative and an out-of-range value
        got_q.delete();
        cycle(1'b1, -3, 1'b1, 1'b0);
        cycle(1'b1, 40000, 1'b1, 1'b0);
        for (int i = 0; i < LEN - 2; i++) cycle(1'b1, i, 1'b1, 1'b0);
        repeat (LEN + 1) cycle(1'b0, 0, 1'b1, 1'b0);
        check_val("t3_neg", got_q[0], 32'hFFFD_0000);
`ifdef FEEDER_SAT_EN
        check_val("t3_big", got_q[1], 32'h7FFF_FFFF);
        check_val("t3_sat", 32'(sat_seen), 32'd1);
`else
        check_val("t3_big", got_q[1], 32'h9C40_0000);
        check_val("t3_sat", 32'(sat_seen), 32'd0);
`endif

        // 4: clear after 5 inputs, then a fresh frame 10..17
        got_q.delete();
        for (int i = 0; i < 5; i++) cycle(1'b1, 50 + i, 1'b1, 1'b0);
        cycle(1'b1, 99, 1'b1, 1'b1);
        for (int i = 10; i <= 17; i++) cycle(1'b1, i, 1'b1, 1'b0);
        repeat (LEN + 1) cycle(1'b0, 0, 1'b1, 1'b0);
        check_val("t4_count", 32'(got_q.size()), 32'(LEN));
        check_val("t4_first", got_q[0], 32'h000A_0000);
        check_val("t4_last", got_q[LEN-1], 32'h0011_0000);

        // 5: async reset mid-drain at rd_ptr == 3
        for (int i = 0; i < LEN; i++) cycle(1'b1, 30 + i, 1'b1, 1'b0);
        repeat (3) cycle(1'b0, 0, 1'b1, 1'b0);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_val("t5_valid", 32'(bus.out_valid), 32'd0);
        check_val("t5_ready", 32'(bus.in_ready), 32'd1);
        check_val("t5_sat", 32'(sat_seen), 32'd0);
        fill_q.delete();
        drain_q.delete();
        sat_exp = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        got_q.delete();
        for (int i = 20; i < 20 + LEN; i++) cycle(1'b1, i, 1'b1, 1'b0);
        repeat (LEN + 1) cycle(1'b0, 0, 1'b1, 1'b0);
        check_val("t5_count", 32'(got_q.size()), 32'(LEN));
        check_val("t5_first", got_q[0], 32'h0014_0000);

        // 6: in_valid held high across two frames
        got_q.delete();
        for (int i = 0; i < 4 * LEN + 2; i++) cycle(1'b1, 100 + i, 1'b1, 1'b0);
        cycle(1'b0, 0, 1'b1, 1'b1);
        check_val("t6_count", 32'(got_q.size()), 32'(2 * LEN));
        check_val("t6_f1_last", got_q[LEN-1], 32'(100 + LEN - 1) << 16);
        check_val("t6_f2_first", got_q[LEN], 32'(100 + 2 * LEN) << 16);
        cycle(1'b0, 0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
